byte_serial_adder: RTL and testbench
====================================

# byte_serial_adder

Multi-byte adder that sequences wide operands through the team's 8-bit `ripple_carry_adder`, one byte per cycle, least-significant byte first. A registered carry links the bytes. It sits directly upstream of the 8-bit adder: it feeds the adder operand bytes and carry-in, and it consumes the adder's sum and carry-out. Valid/ready handshakes on both sides let it drop into a streaming datapath. It gives wide additions without a wide combinational carry chain.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal values are 1 to 16.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset; one clock, asynchronous, active-low.
- `in_valid`  in  1: operands and carry-in are presented.
- `in_ready`  out  1: the block will accept operands this cycle.
- `in_a`  in  8*NBYTES: operand A, unsigned or two's complement.
- `in_b`  in  8*NBYTES: operand B.
- `in_cin`  in  1: carry into byte 0.
- `out_valid`  out  1: result is available.
- `out_ready`  in  1: downstream accepts the result.
- `out_sum`  out  8*NBYTES: `in_a + in_b + in_cin`, modulo 2^(8*NBYTES).
- `out_cout`  out  1: carry out of the MSB.
- `out_ovf`  out  1: signed overflow.
- `busy`  out  1: high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid` is high, capture `in_a` and `in_b` into shift registers, load the carry register with `in_cin`, clear the byte counter, and go to RUN.
  - RUN: the adder sees `a_sh[7:0]`, `b_sh[7:0]` and the carry register.
    - The result shifts right by 8 and takes the adder sum in its top byte.
    - The carry register takes the adder carry-out.
    - The operand shift registers shift right by 8, and the counter increments.
    - When counter = NBYTES-1, go to DONE.
  - DONE: `out_valid`=1, and outputs hold stable. When `out_ready` is high, go to IDLE.
- `in_ready` is high only in IDLE. While `in_ready` is low, `in_valid` is ignored, and there is no accept in the same cycle that DONE retires.
- `out_cout` is the final value of the carry register.
- `out_ovf` is computed on the last byte: (A bit 8N-1 == B bit 8N-1) and (sum bit 8N-1 != A bit 8N-1). It is registered with the last byte.
- `out_sum`, `out_cout` and `out_ovf` keep their last value after the handshake until the next result overwrites them.
- Counter width is $clog2(NBYTES)+1. With NBYTES=1, RUN lasts exactly one cycle.
- `in_cin`=1 with all-ones operands gives a sum of all-ones and `out_cout`=1.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `out_sum`=0, `out_cout`=0, `out_ovf`=0.
  - Carry register, counter and shift registers are all 0.
- Reset is asynchronous: assertion clears everything immediately, including in mid-RUN or DONE. Any in-flight transaction is dropped, with no partial output.
- Latency: the accept edge is T. The RUN edges are T+1 … T+NBYTES. `out_valid` is high starting at edge T+NBYTES.
- Minimum cycles per operation is NBYTES+2: accept, NBYTES run cycles, and one DONE cycle with `out_ready`=1.
- Backpressure in DONE holds all outputs stable for any duration.
- Combinational path per cycle is one 8-bit ripple chain. No input-to-output combinational paths are allowed except `in_ready`, which is derived from state.

## Structure
- Shared package holds:
  - the state encoding constants IDLE, RUN, DONE (2-bit);
  - the byte width constant 8.
- Exactly one sub-module, the existing `ripple_carry_adder`, instantiated once. All sequencing and registers live in `byte_serial_adder`.

## Test plan
- NBYTES=4, A=0x000000C8, B=0x00000022, cin=0 → `out_sum`=0x000000EA, `out_cout`=0, `out_ovf`=0. `out_valid` rises 4 edges after accept.
- A=0xFFFFFFFF, B=0x00000001, cin=0 → `out_sum`=0x00000000, `out_cout`=1, `out_ovf`=0. This exercises the carry crossing every byte.
- A=0x7FFFFFFF, B=0x00000000, cin=1 → `out_sum`=0x80000000, `out_cout`=0, `out_ovf`=1.
- Hold `out_ready`=0 for 10 cycles in DONE while toggling `in_valid` → outputs stable, `in_ready`=0, no capture. Then `out_ready`=1 → IDLE, and the next operation is correct.
- Assert `rst_n`=0 during the second RUN cycle → all outputs go to 0 immediately. After release `in_ready`=1, and a fresh A=56, B=74 gives 130.
- NBYTES=1, A=254, B=30, cin=0 → `out_sum`=0x1C, `out_cout`=1. `out_valid` is high 1 edge after accept.

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// Shared constants for the byte-serial adder: state encoding and byte width.
package byte_serial_adder_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; one full-adder cell per bit.
module ripple_carry_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   logic w_c;

   always_comb begin
      w_c   = i_cin;
      o_sum = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
         w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_c;
   end

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder that streams operands through one 8-bit ripple adder, LSB byte first,
// with valid/ready handshakes on both sides.
module byte_serial_adder
   import byte_serial_adder_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] in_a,
   input  logic [BYTE_W*NBYTES-1:0] in_b,
   input  logic                     in_cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] out_sum,
   output logic                     out_cout,
   output logic                     out_ovf,
   output logic                     busy
);

   localparam int unsigned W     = BYTE_W * NBYTES;
   localparam int unsigned CNT_W = $clog2(NBYTES) + 1;

   state_e             r_state;
   state_e             w_state_next;
   logic [W-1:0]       r_a_sh;
   logic [W-1:0]       r_b_sh;
   logic [W-1:0]       r_res;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [W-1:0]       r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [BYTE_W-1:0]  w_add_sum;
   logic               w_add_cout;
   logic [W-1:0]       w_res_next;
   logic               w_last;

   ripple_carry_adder #(
      .WIDTH (BYTE_W)
   ) u_rca (
      .i_a    (r_a_sh[BYTE_W-1:0]),
      .i_b    (r_b_sh[BYTE_W-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_add_sum),
      .o_cout (w_add_cout)
   );

   // New sum byte enters at the top so the LSB byte ends up at the bottom.
   generate
      if (NBYTES == 1) begin : g_res_single
         assign w_res_next = w_add_sum;
      end else begin : g_res_multi
         assign w_res_next = {w_add_sum, r_res[W-1:BYTE_W]};
      end
   endgenerate

   assign w_last = (r_cnt == CNT_W'(NBYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_sh  <= in_a;
                  r_b_sh  <= in_b;
                  r_carry <= in_cin;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_a_sh  <= r_a_sh >> BYTE_W;
               r_b_sh  <= r_b_sh >> BYTE_W;
               r_res   <= w_res_next;
               r_carry <= w_add_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               // Outputs only change here, so they hold through DONE and after retire.
               if (w_last) begin
                  r_sum  <= w_res_next;
                  r_cout <= w_add_cout;
                  r_ovf  <= (r_a_sh[BYTE_W-1] == r_b_sh[BYTE_W-1]) &&
                            (w_add_sum[BYTE_W-1] != r_a_sh[BYTE_W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sum  = r_sum;
   assign out_cout = r_cout;
   assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed + random bench for byte_serial_adder at NBYTES=4 and NBYTES=1.
module tb_byte_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4;
   logic [31:0] in_a4, in_b4, out_sum4;
   logic        out_cout4, out_ovf4, busy4;

   logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1;
   logic [7:0]  in_a1, in_b1, out_sum1;
   logic        out_cout1, out_ovf1, busy1;

   int checks   = 0;
   int failures = 0;

   logic [31:0] e_sum;
   logic        e_cout, e_ovf;

   always #5 clk = ~clk;

   byte_serial_adder #(.NBYTES(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_a      (in_a4),
      .in_b      (in_b4),
      .in_cin    (in_cin4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_sum   (out_sum4),
      .out_cout  (out_cout4),
      .out_ovf   (out_ovf4),
      .busy      (busy4)
   );

   byte_serial_adder #(.NBYTES(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .in_a      (in_a1),
      .in_b      (in_b1),
      .in_cin    (in_cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .out_sum   (out_sum1),
      .out_cout  (out_cout1),
      .out_ovf   (out_ovf1),
      .busy      (busy1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide arithmetic, width given in bits.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int bits, output logic [31:0] sum, output logic cout,
                        output logic ovf);
      logic [32:0] t;
      logic [32:0] m;
      m    = (33'd1 << bits) - 33'd1;
      t    = ({1'b0, a} & m) + ({1'b0, b} & m) + 33'(cin);
      sum  = 32'(t & m);
      cout = t[bits];
      ovf  = (a[bits-1] == b[bits-1]) && (t[bits-1] != a[bits-1]);
   endtask

   // Accept one operation on the 4-byte DUT and wait for its result.
   task automatic start_op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input string tag);
      int lat;
      model(a, b, cin, 32, e_sum, e_cout, e_ovf);
      @(negedge clk);
      check({tag, ".in_ready"}, 64'(in_ready4), 64'd1);
      in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      check({tag, ".busy"}, 64'(busy4), 64'd1);
      lat = 0;
      while (!out_valid4 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'd4);
      check({tag, ".sum"}, 64'(out_sum4), 64'(e_sum));
      check({tag, ".cout"}, 64'(out_cout4), 64'(e_cout));
      check({tag, ".ovf"}, 64'(out_ovf4), 64'(e_ovf));
   endtask

   task automatic finish_op4(input string tag);
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check({tag, ".retire_valid"}, 64'(out_valid4), 64'd0);
      check({tag, ".retire_ready"}, 64'(in_ready4), 64'd1);
      check({tag, ".held_sum"}, 64'(out_sum4), 64'(e_sum));
   endtask

   task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input string tag);
      int lat;
      logic [31:0] s;
      logic c, o;
      model({24'd0, a}, {24'd0, b}, cin, 8, s, c, o);
      @(negedge clk);
      in_a1 = a; in_b1 = b; in_cin1 = cin; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'd1);
      check({tag, ".sum"}, 64'(out_sum1), 64'(s[7:0]));
      check({tag, ".cout"}, 64'(out_cout1), 64'(c));
      check({tag, ".ovf"}, 64'(out_ovf1), 64'(o));
      @(negedge clk);
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      check({tag, ".retire"}, 64'(in_ready1), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rc;
      rst_n = 1'b0;
      in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_cin4 = 0; out_ready4 = 0;
      in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; out_ready1 = 0;
      #12;
      check("rst.in_ready", 64'(in_ready4), 64'd1);
      check("rst.out_valid", 64'(out_valid4), 64'd0);
      check("rst.busy", 64'(busy4), 64'd0);
      check("rst.outs", {31'd0, out_cout4, out_ovf4, out_sum4}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      start_op4(32'h0000_00C8, 32'h0000_0022, 1'b0, "small");
      finish_op4("small");
      start_op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "carry_all");
      finish_op4("carry_all");
      start_op4(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, "ovf");
      finish_op4("ovf");
      start_op4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ones_cin");
      finish_op4("ones_cin");

      // Backpressure: results must hold and new operands must be ignored.
      start_op4(32'h1234_5678, 32'h8765_4321, 1'b1, "bp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid4 = ~in_valid4;
         in_a4 = $urandom; in_b4 = $urandom;
         @(posedge clk); #1;
         check("bp.valid", 64'(out_valid4), 64'd1);
         check("bp.in_ready", 64'(in_ready4), 64'd0);
         check("bp.sum", {31'd0, out_cout4, out_sum4}, {31'd0, e_cout, e_sum});
      end
      in_valid4 = 1'b0;
      finish_op4("bp");
      start_op4(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, "after_bp");
      finish_op4("after_bp");

      // Reset during the second RUN cycle drops the transaction.
      @(negedge clk);
      in_a4 = 32'hAAAA_AAAA; in_b4 = 32'h5555_5555; in_cin4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst.outs", {31'd0, out_cout4, out_ovf4, out_sum4}, 64'd0);
      check("mid_rst.valid", 64'(out_valid4), 64'd0);
      check("mid_rst.busy", 64'(busy4), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst.in_ready", 64'(in_ready4), 64'd1);
      start_op4(32'd56, 32'd74, 1'b0, "post_rst");
      finish_op4("post_rst");

      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom);
         start_op4(ra, rb, rc, "rand4");
         finish_op4("rand4");
      end

      op1(8'd254, 8'd30, 1'b0, "n1");
      op1(8'h7F, 8'h01, 1'b0, "n1_ovf");
      op1(8'hFF, 8'hFF, 1'b1, "n1_ones");
      for (int i = 0; i < 8; i++) begin
         op1(8'($urandom), 8'($urandom), 1'($urandom), "rand1");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
